// File: rtl/mem_arbiter.sv
// Arbitrates one main-memory port between the I-cache and D-cache fill engines
// and routes returning read data to its owner. Define ARB_ROUND_ROBIN_EN for round-robin on ties.
module mem_arbiter #(
  parameter int LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_data_valid,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_wr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic        d_data_valid,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_data_valid,
  output logic        mem_busy
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;

  localparam logic       SIDE_I  = 1'b0;
  localparam logic       SIDE_D  = 1'b1;
  localparam logic [3:0] CNT_MAX = 4'hF;

  generate
    if (LAT < 1) begin : g_lat_check
      $error("mem_arbiter: LAT must be at least 1");
    end
  endgenerate

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       owner_q, owner_d;
  logic       pick_d;
  logic       rd_issue, rd_return;

`ifdef ARB_ROUND_ROBIN_EN
  logic       last_q, last_d;
`endif

  always_comb begin
    i_grant   = (state_q == GNT_I);
    d_grant   = (state_q == GNT_D);
    mem_busy  = (state_q != IDLE);
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0;
    mem_wdata = 16'h0;
    if (i_grant) begin
      mem_en   = i_req;
      mem_addr = i_addr;
    end else if (d_grant) begin
      mem_en    = d_req;
      mem_wr    = d_wr;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // A return with nothing outstanding is stray and neither counted nor routed.
  assign rd_issue     = mem_en & ~mem_wr;
  assign rd_return    = mem_data_valid & (cnt_q != 4'h0);
  assign i_data_valid = rd_return & (owner_q == SIDE_I);
  assign d_data_valid = rd_return & (owner_q == SIDE_D);

  always_comb begin
    cnt_d = cnt_q;
    if (rd_issue && !rd_return && cnt_q != CNT_MAX) cnt_d = cnt_q + 4'h1;
    else if (rd_return && !rd_issue)                cnt_d = cnt_q - 4'h1;
  end

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req) pick_d = (last_q == SIDE_I);
    else                pick_d = d_req;
`else
    pick_d = d_req;
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          state_d = pick_d ? GNT_D : GNT_I;
          owner_d = pick_d;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = pick_d;
`endif
        end
      end
      GNT_I: if (!i_req) state_d = (cnt_d == 4'h0) ? IDLE : DRAIN;
      GNT_D: if (!d_req) state_d = (cnt_d == 4'h0) ? IDLE : DRAIN;
      DRAIN: if (cnt_d == 4'h0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'h0;
      owner_q <= SIDE_I;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= SIDE_I;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT-cycle memory model plus a routing scoreboard
// that predicts which side each read return belongs to.
module tb_mem_arbiter;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, i_data_valid, d_grant, d_data_valid;
  logic        mem_en, mem_wr, mem_busy, mem_data_valid;
  logic [15:0] mem_addr, mem_wdata;

  int errors = 0;
  int checks = 0;

  logic [LAT-1:0] dl     = '0;
  logic           en_cap = 1'b0;
  logic           stray  = 1'b0;
  logic           mon_on = 1'b0;
  logic           exp_side = 1'b0;   // 1 = D side expected to own reads being issued
  logic [1:0]     sb_q[$];           // expected {i_data_valid, d_data_valid} per read
  int             ipulse = 0, dpulse = 0;
  int             p0;

  assign mem_data_valid = dl[LAT-1] | stray;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data_valid(i_data_valid),
    .d_req(d_req), .d_addr(d_addr), .d_wr(d_wr), .d_wdata(d_wdata),
    .d_grant(d_grant), .d_data_valid(d_data_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_data_valid(mem_data_valid), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: a read strobed in cycle k returns in cycle k+LAT.
  initial forever begin
    @(posedge clk); #1;
    dl = {dl[LAT-2:0], en_cap};
  end

  always @(negedge clk) begin
    en_cap = mem_en && !mem_wr;
    if (mon_on) begin
      if (mem_en && !mem_wr) sb_q.push_back(exp_side ? 2'b01 : 2'b10);
      if (i_data_valid) ipulse++;
      if (d_data_valid) dpulse++;
      if (dl[LAT-1]) begin
        if (sb_q.size() == 0) chk1("sb_underflow", 1'b1, 1'b0);
        else chk16("route", 16'({i_data_valid, d_data_valid}), 16'(sb_q.pop_front()));
      end else begin
        chk16("route_idle", 16'({i_data_valid, d_data_valid}), 16'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reads(input logic side, input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      if (side) d_addr = base + 16'(2 * k);
      else      i_addr = base + 16'(2 * k);
      #1;
      chk1("rd_en", mem_en, 1'b1);
      chk1("rd_wr", mem_wr, 1'b0);
      chk16("rd_addr", mem_addr, base + 16'(2 * k));
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_grant(input string tag, input logic side);
    for (int k = 0; k < 40; k++) begin
      if (side ? d_grant : i_grant) break;
      step();
    end
    chk1(tag, side ? d_grant : i_grant, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40; k++) begin
      if (!mem_busy) break;
      step();
    end
    chk1(tag, mem_busy, 1'b0);
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_igr"}, i_grant, 1'b0);
    chk1({tag, "_dgr"}, d_grant, 1'b0);
    chk1({tag, "_en"}, mem_en, 1'b0);
    chk1({tag, "_wr"}, mem_wr, 1'b0);
    chk16({tag, "_addr"}, mem_addr, 16'h0);
    chk16({tag, "_wdata"}, mem_wdata, 16'h0);
    chk1({tag, "_busy"}, mem_busy, 1'b0);
    chk16({tag, "_cnt"}, 16'(dut.cnt_q), 16'h0);
  endtask

  initial begin
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
    step(); step();
    chk_quiet("reset");
    rst = 1'b1; mon_on = 1'b1;
    step();

    // I-only fill of 8 words, then drain
    i_req = 1'b1; i_addr = 16'h1230; exp_side = 1'b0;
    step();
    chk1("i_fill_grant", i_grant, 1'b1);
    chk1("i_fill_dgr", d_grant, 1'b0);
    p0 = ipulse;
    reads(1'b0, 16'h1230, 8);
    i_req = 1'b0;
    step();
    chk1("i_fill_drain_gr", i_grant, 1'b0);
    chk1("i_fill_drain_busy", mem_busy, 1'b1);
    wait_idle("i_fill_idle");
    chk16("i_fill_pulses", 16'(ipulse - p0), 16'd8);
    chk16("i_fill_cnt", 16'(dut.cnt_q), 16'h0);
    chk16("i_fill_sb", 16'(sb_q.size()), 16'h0);

    // Simultaneous requests after reset: D first, I after D drains
    i_req = 1'b1; i_addr = 16'h2000; d_req = 1'b1; d_addr = 16'h0400;
    step();
    chk1("sim_dgr", d_grant, 1'b1);
    chk1("sim_igr", i_grant, 1'b0);
    p0 = dpulse; exp_side = 1'b1;
    reads(1'b1, 16'h0400, 2);
    d_req = 1'b0;
    wait_grant("sim_i_after_d", 1'b0);
    chk16("sim_d_drained", 16'(dpulse - p0), 16'd2);
    exp_side = 1'b0;
    reads(1'b0, 16'h2000, 2);
    i_req = 1'b0;
    wait_idle("sim_idle");

    // Single-word D write
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h00A0; d_wdata = 16'hBEEF;
    step();
    chk1("wr_grant", d_grant, 1'b1);
    #1;
    chk1("wr_en", mem_en, 1'b1);
    chk1("wr_wr", mem_wr, 1'b1);
    chk16("wr_addr", mem_addr, 16'h00A0);
    chk16("wr_wdata", mem_wdata, 16'hBEEF);
    step();
    d_req = 1'b0; d_wr = 1'b0;
    #1;
    chk1("wr_en_off", mem_en, 1'b0);
    step();
    chk1("wr_idle", mem_busy, 1'b0);
    chk16("wr_cnt", 16'(dut.cnt_q), 16'h0);

    // Tie-break: D write first, then D and I both pending in IDLE
    rst = 1'b0; step(); rst = 1'b1;
    i_req = 1'b1; i_addr = 16'h3000; d_req = 1'b1; d_wr = 1'b1;
    d_addr = 16'h00A2; d_wdata = 16'h1234;
    step();
    chk1("tie1_dgr", d_grant, 1'b1);
    step();
    d_req = 1'b0;
    step();
    chk1("tie_idle_gap", mem_busy, 1'b0);
    d_req = 1'b1;
    step();
`ifdef ARB_ROUND_ROBIN_EN
    chk1("tie2_igr", i_grant, 1'b1);
    chk1("tie2_dgr", d_grant, 1'b0);
    exp_side = 1'b0;
    reads(1'b0, 16'h3000, 1);
    i_req = 1'b0;
    wait_grant("tie2_d_later", 1'b1);
    #1;
    chk1("tie2_wr", mem_wr, 1'b1);
    step();
    d_req = 1'b0; d_wr = 1'b0;
    wait_idle("tie2_idle");
`else
    chk1("tie2_dgr", d_grant, 1'b1);
    chk1("tie2_igr", i_grant, 1'b0);
    #1;
    chk1("tie2_wr", mem_wr, 1'b1);
    step();
    d_req = 1'b0; d_wr = 1'b0;
    wait_grant("tie2_i_later", 1'b0);
    exp_side = 1'b0;
    reads(1'b0, 16'h3000, 1);
    i_req = 1'b0;
    wait_idle("tie2_idle");
`endif
    step(); step(); step(); step(); step();

    // Reset while three reads are still in flight
    i_req = 1'b1; i_addr = 16'h4000; exp_side = 1'b0;
    step();
    reads(1'b0, 16'h4000, 3);
    i_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    foreach (sb_q[j]) sb_q[j] = 2'b00;
    rst = 1'b1;
    chk_quiet("mid_rst");
    chk1("mid_rst_idv", i_data_valid, 1'b0);
    step(); step(); step(); step();
    chk16("mid_rst_sb", 16'(sb_q.size()), 16'h0);
    chk16("mid_rst_cnt", 16'(dut.cnt_q), 16'h0);

    // Stray return with nothing outstanding
    stray = 1'b1;
    #1;
    chk1("stray_idv", i_data_valid, 1'b0);
    chk1("stray_ddv", d_data_valid, 1'b0);
    step();
    stray = 1'b0;
    chk16("stray_cnt", 16'(dut.cnt_q), 16'h0);
    chk1("stray_busy", mem_busy, 1'b0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
